// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, STATUS bit positions and reset constants shared by
// the MMIO responder and its transmit FIFO.
package mmio_pkg;

  // Word offsets within the register window (Addr[4:2])
  localparam logic [2:0] OFF_TXDATA  = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_TIMER   = 3'd2;
  localparam logic [2:0] OFF_COMPARE = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;

  // STATUS bit positions
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_FLAG  = 8;
  localparam int ST_CNT   = 11;   // count occupies [15:11]
  localparam int ST_CNT_W = 5;

  // CTRL bit positions
  localparam int CTRL_TMR_EN = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_fifo.sv
// mmio_fifo: byte FIFO with head-of-queue output. A push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module mmio_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Head forced to 0 when empty so the sink sees 0 out of reset.
  assign rdata   = empty ? 8'h00 : mem[rp];

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: data-memory-port target with a byte TX FIFO and an optional
// compare-match timer. Reads are combinational, writes commit on the clock.
// Define MMIO_TIMER_EN to build the timer, COMPARE, CTRL and Irq logic.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h0000_7F00,
  parameter int          DEPTH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        Sel,
  output logic [31:0] RData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  output logic        Irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]    off;
  logic          wr, st_wr, push, pop, full, empty, ovf;
  logic [CW-1:0] count;
  logic [31:0]   timer, compare;
  logic [1:0]    ctrl;
  logic          flag;
  logic          unused_bits;

  assign off   = Addr[4:2];
  assign Sel   = (Addr[31:5] == BASE[31:5]);
  assign wr    = MemWrite & Sel;
  assign st_wr = wr && (off == OFF_STATUS);
  assign push  = wr && (off == OFF_TXDATA);
  assign pop   = TxValid & TxReady;

  assign unused_bits = &{1'b0, Addr[1:0], WData[31:8]};

  mmio_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .wdata (WData[7:0]),
    .pop   (pop),
    .rdata (TxData),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign TxValid = ~empty;

  // Sticky overflow: a dropped push sets it; a set beats a same-cycle clear.
  always_ff @(posedge Clk) begin
    if (Reset)                          ovf <= 1'b0;
    else if (push & full & ~pop)        ovf <= 1'b1;
    else if (st_wr & WData[ST_OVF])     ovf <= 1'b0;
  end

`ifdef MMIO_TIMER_EN
  logic tmr_wr, match;

  assign tmr_wr = wr && (off == OFF_TIMER);
  assign match  = ctrl[CTRL_TMR_EN] && (timer == compare);

  // Timer, compare, control and match flag; a software TIMER write overrides
  // both the increment and the match reload, and suppresses the flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      timer   <= '0;
      compare <= COMPARE_RST;
      ctrl    <= '0;
      flag    <= 1'b0;
    end else begin
      if (tmr_wr)                  timer <= WData;
      else if (match)              timer <= '0;
      else if (ctrl[CTRL_TMR_EN])  timer <= timer + 32'd1;
      if (wr && (off == OFF_COMPARE)) compare <= WData;
      if (wr && (off == OFF_CTRL))    ctrl    <= WData[1:0];
      if (match && !tmr_wr)               flag <= 1'b1;
      else if (st_wr && WData[ST_FLAG])   flag <= 1'b0;
    end
  end

  assign Irq = flag & ctrl[CTRL_IRQ_EN];
`else
  assign timer   = '0;
  assign compare = '0;
  assign ctrl    = '0;
  assign flag    = 1'b0;
  assign Irq     = 1'b0;
`endif

  // Read mux: zero unless this is a load that hits the window.
  always_comb begin
    RData = '0;
    if (MemRead && Sel) begin
      case (off)
        OFF_STATUS: begin
          RData[ST_FULL]             = full;
          RData[ST_EMPTY]            = empty;
          RData[ST_OVF]              = ovf;
          RData[ST_FLAG]             = flag;
          RData[ST_CNT +: ST_CNT_W]  = ST_CNT_W'(count);
        end
        OFF_TIMER:   RData = timer;
        OFF_COMPARE: RData = compare;
        OFF_CTRL:    RData = {30'd0, ctrl};
        default:     RData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed checks of the MMIO responder register map,
// TX FIFO handshake/overflow and (when MMIO_TIMER_EN is defined) the timer.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_TX = BASE + 32'h00;
  localparam logic [31:0] A_ST = BASE + 32'h04;
  localparam logic [31:0] A_TM = BASE + 32'h08;
  localparam logic [31:0] A_CP = BASE + 32'h0C;
  localparam logic [31:0] A_CT = BASE + 32'h10;
  localparam logic [31:0] A_R5 = BASE + 32'h14;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        Sel;
  logic [31:0] RData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;
  logic        Irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  mmio_responder #(.BASE(BASE), .DEPTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .WData(WData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Sel(Sel), .RData(RData),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one store across the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    Addr = a; WData = v; MemWrite = 1'b1;
    @(negedge Clk);
    MemWrite = 1'b0;
  endtask

  // Combinational load, sampled 1 ns after driving.
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    Addr = a; MemRead = 1'b1;
    #1 v = RData;
    MemRead = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Reset state
    rd(A_ST, d); chk("rst_status", d, 32'h2);
    chk("rst_txvalid", {31'd0, TxValid}, 0);
    chk("rst_txdata", {24'd0, TxData}, 0);
    chk("rst_irq", {31'd0, Irq}, 0);
`ifdef MMIO_TIMER_EN
    rd(A_CP, d); chk("rst_compare", d, 32'hFFFF_FFFF);
`else
    rd(A_CP, d); chk("rst_compare_off", d, 0);
`endif
    @(negedge Clk);

    // Decode: select, no-load read, out-of-window access, reserved offset
    Addr = A_ST; #1 chk("sel_hit", {31'd0, Sel}, 1);
    chk("rdata_noread", RData, 0);
    Addr = BASE + 32'h24; #1 chk("sel_miss", {31'd0, Sel}, 0);
    rd(BASE + 32'h24, d); chk("rd_miss", d, 0);
    wr(BASE + 32'h20, 32'h77);
    wr(A_R5, 32'h1234);
    rd(A_ST, d); chk("miss_wr_noeffect", d, 32'h2);
    rd(A_R5, d); chk("rd_off5", d, 0);
    rd(A_TX, d); chk("rd_txdata", d, 0);
    @(negedge Clk);

    // Three pushes, then drain on consecutive cycles
    wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'hFFFF_FF43);
    chk("fifo_valid", {31'd0, TxValid}, 1);
    chk("fifo_head", {24'd0, TxData}, 32'h41);
    rd(A_ST, d); chk("fifo_cnt3", d, 32'h1800);
    TxReady = 1'b1;
    #1 chk("drain0", {24'd0, TxData}, 32'h41);
    @(negedge Clk); chk("drain1", {24'd0, TxData}, 32'h42);
    @(negedge Clk); chk("drain2", {24'd0, TxData}, 32'h43);
    @(negedge Clk); chk("drain_empty", {31'd0, TxValid}, 0);
    rd(A_ST, d); chk("drain_status", d, 32'h2);

    // Push into empty with TxReady high: no pop of the new byte that cycle
    wr(A_TX, 32'h55);
    chk("epush_valid", {31'd0, TxValid}, 1);
    chk("epush_data", {24'd0, TxData}, 32'h55);
    rd(A_ST, d); chk("epush_cnt", d, 32'h0800);
    @(negedge Clk); chk("epush_popped", {31'd0, TxValid}, 0);
    TxReady = 1'b0;

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + i);
    rd(A_ST, d); chk("ovf_status", d, 32'h4005);
    chk("ovf_head", {24'd0, TxData}, 32'h10);
    wr(A_ST, 32'h4);
    rd(A_ST, d); chk("ovf_clear", d, 32'h4001);

    // Push while popping when full: accepted, count stays 8, no overflow
    TxReady = 1'b1;
    wr(A_TX, 32'h99);
    TxReady = 1'b0;
    rd(A_ST, d); chk("fullpp_status", d, 32'h4001);
    chk("fullpp_head", {24'd0, TxData}, 32'h11);
    TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("fullpp_drain", {24'd0, TxData}, (i < 7) ? 32'h11 + i : 32'h99);
      @(negedge Clk);
    end
    TxReady = 1'b0;
    chk("fullpp_empty", {31'd0, TxValid}, 0);

    // Reset mid-transfer discards contents
    wr(A_TX, 32'hA1); wr(A_TX, 32'hA2);
    Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
    chk("rstmid_valid", {31'd0, TxValid}, 0);
    rd(A_ST, d); chk("rstmid_status", d, 32'h2);
    @(negedge Clk);

`ifdef MMIO_TIMER_EN
    // Compare match: flag/Irq rise 6 cycles after the CTRL write edge
    wr(A_CP, 32'd5); wr(A_CT, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clk); chk("tmr_irq_low", {31'd0, Irq}, 0);
    end
    rd(A_TM, d); chk("tmr_at5", d, 32'd5);
    @(negedge Clk);
    chk("tmr_irq_high", {31'd0, Irq}, 1);
    rd(A_TM, d); chk("tmr_reload", d, 0);
    rd(A_ST, d); chk("tmr_flag", d, 32'h102);
    wr(A_ST, 32'h100);
    chk("tmr_irq_clr", {31'd0, Irq}, 0);
    rd(A_TM, d); chk("tmr_after_clr", d, 32'd1);

    // TIMER write in the match cycle wins; no flag
    wr(A_CT, 32'd0); wr(A_TM, 32'd5); wr(A_CT, 32'd3);
    wr(A_TM, 32'h1234);
    rd(A_TM, d); chk("wrmatch_timer", d, 32'h1234);
    rd(A_ST, d); chk("wrmatch_noflag", d, 32'h2);

    // Get the flag set, then clear it in a match cycle: set wins
    wr(A_CT, 32'd0); wr(A_TM, 32'd5); wr(A_CT, 32'd3);
    @(negedge Clk); chk("setup_flag", {31'd0, Irq}, 1);
    wr(A_CT, 32'd0); wr(A_TM, 32'd5); wr(A_CT, 32'd3);
    wr(A_ST, 32'h100);
    chk("clrset_irq", {31'd0, Irq}, 1);
    rd(A_ST, d); chk("clrset_status", d, 32'h102);
    rd(A_TM, d); chk("clrset_timer", d, 0);
    wr(A_CT, 32'd1);
    chk("irq_gated", {31'd0, Irq}, 0);
    rd(A_CT, d); chk("ctrl_rd", d, 32'd1);
`else
    // Timer absent: registers read 0, Irq never rises
    wr(A_CP, 32'd5); wr(A_CT, 32'd3); wr(A_TM, 32'h77);
    for (int i = 0; i < 8; i++) begin
      rd(A_TM, d); chk("notmr_timer", d, 0);
      chk("notmr_irq", {31'd0, Irq}, 0);
      @(negedge Clk);
    end
    rd(A_CT, d); chk("notmr_ctrl", d, 0);
    rd(A_CP, d); chk("notmr_compare", d, 0);
    rd(A_ST, d); chk("notmr_status", d, 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped peripheral responder on the single-cycle CPU's data-memory port, the target side of the core's load/store accesses. It decodes a small register window, returns read data combinationally within the same cycle as the load, and commits writes on the clock edge. It owns a byte transmit FIFO drained through a valid/ready handshake, plus a compare-match timer with an interrupt line.

## Interface
- BASE, 32'h0000_7F00, word-aligned base of the 32-byte register window
- DEPTH, 8, TX FIFO entries (power of two, 2..16)
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Addr  in  32  CPU data address
- WData  in  32  CPU store data
- MemWrite  in  1  store strobe, committed at the rising edge of Clk
- MemRead  in  1  load strobe
- Sel  out  1  combinational: Addr[31:5] == BASE[31:5]; the CPU muxes RData instead of data memory
- RData  out  32  combinational read data; 0 when !MemRead or !Sel
- TxData  out  8  FIFO head byte
- TxValid  out  1  FIFO non-empty
- TxReady  in  1  sink accepts; pop when TxValid & TxReady at the edge
- Irq  out  1  timer flag & CTRL.irq_en

## Operation
- Registers at offset Addr[4:2]: 0 TXDATA, 1 STATUS, 2 TIMER, 3 COMPARE, 4 CTRL; offsets 5-7 read 0, writes ignored.
- TXDATA: a write pushes WData[7:0]; reads return 0.
- STATUS (read): bit0 full, bit1 empty, bit2 overflow (sticky), bit8 timer flag (sticky), bits[15:11] count.
- STATUS (write): writing 1 to bit2 or bit8 clears that bit. All other bits are read-only.
- TIMER and COMPARE are 32-bit read/write. CTRL bit0 is tmr_en, bit1 is irq_en; the other bits read 0.
- FIFO full rule: a push while full with no pop in the same cycle is dropped and sets overflow.
- FIFO push and pop in the same cycle:
  - full: the push is accepted and count is unchanged.
  - empty: only the push takes effect; TxValid was low, so no pop occurs.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- Timer: when tmr_en is set, TIMER increments by 1 each cycle (wraps at 2^32). When TIMER == COMPARE, TIMER loads 0 on the next edge and the flag is set.
- A software write to TIMER wins over both increment and match in that cycle; the flag is not set that cycle.
- If a flag clear and a flag set occur in the same cycle, set wins.
- Accesses with !Sel have no effect on any state.

## Timing
- Reset values:
  - TxValid 0, TxData 0, Irq 0
  - FIFO empty, overflow 0
  - TIMER 0, COMPARE 32'hFFFF_FFFF, CTRL 0, flag 0
- Reset mid-transfer discards FIFO contents. TxValid falls at the reset edge.
- Read latency 0: RData is valid in the same cycle as MemRead.
- Write latency 1: state updates at the rising edge where MemWrite is high.
- A push into an empty FIFO raises TxValid in the cycle after the write edge; TxData must be stable while TxValid & !TxReady.
- Timer match at cycle k: the flag and Irq are high from k+1, and TIMER reads 0 at k+1.

## Configuration
- MMIO_TIMER_EN defined: timer, COMPARE, CTRL bit0, the flag and Irq are implemented as above.
- MMIO_TIMER_EN undefined: TIMER, COMPARE and STATUS bit8 read 0, their writes are ignored, and Irq is tied 0. CTRL bits read 0. The FIFO is unaffected.

## Structure
- Package mmio_pkg holds:
  - register offset constants (OFF_TXDATA..OFF_CTRL)
  - STATUS bit positions
  - the COMPARE reset constant
- Sub-module mmio_fifo (parameter DEPTH, width 8): push/pop/full/empty/count, with same-cycle push and pop handled per the rules above. The responder instantiates it once.

## Test plan
- Reset, then read STATUS: returns 0x0000_0002 (empty), TxValid=0, Irq=0; read COMPARE returns 0xFFFF_FFFF.
- Write 0x41, 0x42, 0x43 to TXDATA with TxReady=0: TxValid=1, TxData=0x41, STATUS count=3. Raise TxReady: bytes 0x41/0x42/0x43 appear on three consecutive cycles, then empty.
- Overflow and simultaneous push/pop:
  - Push 9 bytes with TxReady=0 (DEPTH=8): STATUS=0x4005 (count 8, full, overflow).
  - Write 0x4 to STATUS: overflow clears.
  - Push while popping when full: count stays 8.
- Timer: COMPARE=5, CTRL=3. The flag and Irq rise 6 cycles after the CTRL write edge, and TIMER reads 0 on the first cycle they are high. Writing 0x100 to STATUS clears Irq.
- Write-precedence corners:
  - Write TIMER in the same cycle as a match: the written value is held and no flag is set.
  - A clear and a new match in the same cycle: the flag stays 1.
- Build without MMIO_TIMER_EN, run the timer test: TIMER reads 0 and Irq stays 0 throughout.
